expansao_chave: RTL
===================

EXPANSAO_CHAVE -- requirements
Module: expansao_chave

Interface
REQ-001 Parameter: NUM_RODADAS, 10, number of round keys generated after round 0; legal range 1..10.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 inicio  input  1  start request; sampled only in OCIOSO.
REQ-006 chave  input  128  cipher key; chave[127:96] is w0 and chave[31:0] is w3; sampled on the accepted inicio cycle.
REQ-007 saida_pronta  input  1  downstream ready.
REQ-008 chave_rodada  output  128  current round key, registered.
REQ-009 rodada  output  4  index of the round key on chave_rodada (0..NUM_RODADAS), registered.
REQ-010 saida_valida  output  1  chave_rodada/rodada valid, registered.
REQ-011 ocupado  output  1  high while in state EMITE.
REQ-012 fim  output  1  one-cycle pulse after the final key is accepted, registered.

Function
REQ-013 The block SHALL have two states: OCIOSO and EMITE.
REQ-014 OCIOSO with inicio=1: next edge loads chave into chave_rodada, sets rodada=0 and saida_valida=1, and enters EMITE (key visible one cycle after inicio).
REQ-015 In EMITE, inicio SHALL be ignored and chave SHALL not be resampled.
REQ-016 Transfer occurs on an edge where saida_valida=1 and saida_pronta=1; with saida_pronta=0, chave_rodada, rodada and saida_valida SHALL hold unchanged.
REQ-017 On transfer with rodada<NUM_RODADAS: next edge loads the next round key and sets rodada=rodada+1; saida_valida stays 1, so back-to-back keys are possible, one per cycle.
REQ-018 Next key from current words w0..w3: t=funcaoG(palavra=w3, rodada=current rodada); w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
REQ-019 The existing funcaoG block (RotWord, SubWord, XOR Rcon, where rodada=r gives Rcon 2^r in GF(2^8)) SHALL be instantiated once, combinationally, driven from the chave_rodada register.
REQ-020 On transfer with rodada=NUM_RODADAS: next edge clears saida_valida, pulses fim for exactly one cycle and returns to OCIOSO; chave_rodada and rodada hold their last values.
REQ-021 inicio asserted on the same cycle as the final transfer SHALL be ignored; a new start is accepted only from OCIOSO, at the earliest the cycle fim is high.
REQ-022 ocupado SHALL equal (state==EMITE); it is 0 in the cycle fim is high.
REQ-023 All XOR operations are 32-bit bitwise; no carries, no width growth.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state=OCIOSO, chave_rodada=0, rodada=0, saida_valida=0, ocupado=0 and fim=0.
REQ-025 Reset asserted mid-expansion SHALL abort the expansion with no fim pulse; after release the block waits for a new inicio.
REQ-026 Release of rst_n is synchronous to clk; the first inicio is accepted on the first edge after release.

Verification
REQ-027 Start with chave=2b7e151628aed2a6abf7158809cf4f3c and saida_pronta=1 -> rodada 0 key equals chave; rodada 1 = a0fafe1788542cb123a339392a6c7605; rodada 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; 11 consecutive valid cycles, then fim=1 for one cycle.
REQ-028 Same key, saida_pronta toggled randomly -> identical key sequence with no duplicates or skips, and outputs stable while saida_pronta=0.
REQ-029 inicio pulsed during EMITE with a different chave -> sequence unaffected.
REQ-030 rst_n asserted at rodada=5 -> outputs go to 0 asynchronously with no fim pulse; a restart with the same key reproduces REQ-027.
REQ-031 inicio held high continuously -> a new expansion starts the cycle fim is high and rodada restarts at 0.
REQ-032 NUM_RODADAS=1 -> exactly rodada 0 and rodada 1 (a0fafe17...) are emitted, then fim.

Source files
------------

// File: rtl/expansao_chave_if.sv
// Handshake/bus interface of the key expander.
//   inicio, chave, saida_pronta            : driven by the master (requester)
//   chave_rodada, rodada, saida_valida,
//   ocupado, fim                           : driven by the slave (expansao_chave)
interface expansao_chave_if;
    logic         inicio;
    logic [127:0] chave;
    logic         saida_pronta;
    logic [127:0] chave_rodada;
    logic [3:0]   rodada;
    logic         saida_valida;
    logic         ocupado;
    logic         fim;

    modport master (
        output inicio, chave, saida_pronta,
        input  chave_rodada, rodada, saida_valida, ocupado, fim
    );

    modport slave (
        input  inicio, chave, saida_pronta,
        output chave_rodada, rodada, saida_valida, ocupado, fim
    );
endinterface

// File: rtl/expansao_chave.sv
// AES-128 key expansion, one round key per accepted transfer.
//   funcaoG       : RotWord + SubWord + Rcon(2^i_rodada) on one 32-bit word (combinational).
//   expansao_chave: clk, rst_n (async active-low), bus (expansao_chave_if.slave).
//                   Emits round keys 0..NUM_RODADAS with a valid/ready handshake and
//                   pulses fim for one cycle after the last key is accepted.
module funcaoG (
    input  logic [31:0] i_palavra,
    input  logic [3:0]  i_rodada,
    output logic [31:0] o_palavra
);
    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        // Entry b sits at bit offset 8*(255-b) = {~b, 3'b000}.
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [7:0]  w_rcon;

    assign w_rot = {i_palavra[23:0], i_palavra[31:24]};
    assign w_sub = {sub_byte(w_rot[31:24]), sub_byte(w_rot[23:16]),
                    sub_byte(w_rot[15:8]),  sub_byte(w_rot[7:0])};

    // Rcon = 2^i_rodada in GF(2^8).
    always_comb begin
        w_rcon = 8'h01;
        for (int i = 0; i < 15; i++) begin
            if (i < int'(i_rodada)) begin
                w_rcon = xtime(w_rcon);
            end
        end
    end

    assign o_palavra = w_sub ^ {w_rcon, 24'h000000};
endmodule

module expansao_chave #(
    parameter int unsigned NUM_RODADAS = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    expansao_chave_if.slave    bus
);
    localparam logic [3:0] ULTIMA_RODADA = 4'(NUM_RODADAS);

    typedef enum logic [0:0] {OCIOSO, EMITE} estado_t;

    estado_t      r_estado;
    logic [127:0] r_chave;
    logic [3:0]   r_rodada;
    logic         r_valida;
    logic         r_ocupado;
    logic         r_fim;

    logic [31:0]  w_g;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_proxima;

    funcaoG u_funcao_g (
        .i_palavra (r_chave[31:0]),
        .i_rodada  (r_rodada),
        .o_palavra (w_g)
    );

    assign w_n0      = r_chave[127:96] ^ w_g;
    assign w_n1      = r_chave[95:64]  ^ w_n0;
    assign w_n2      = r_chave[63:32]  ^ w_n1;
    assign w_n3      = r_chave[31:0]   ^ w_n2;
    assign w_proxima = {w_n0, w_n1, w_n2, w_n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= OCIOSO;
            r_chave   <= '0;
            r_rodada  <= '0;
            r_valida  <= 1'b0;
            r_ocupado <= 1'b0;
            r_fim     <= 1'b0;
        end else begin
            r_fim <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (bus.inicio) begin
                        r_chave   <= bus.chave;
                        r_rodada  <= 4'd0;
                        r_valida  <= 1'b1;
                        r_ocupado <= 1'b1;
                        r_estado  <= EMITE;
                    end
                end
                EMITE: begin
                    // saida_valida is always 1 here, so ready alone marks a transfer.
                    if (bus.saida_pronta) begin
                        if (r_rodada < ULTIMA_RODADA) begin
                            r_chave  <= w_proxima;
                            r_rodada <= r_rodada + 4'd1;
                        end else begin
                            r_valida  <= 1'b0;
                            r_ocupado <= 1'b0;
                            r_fim     <= 1'b1;
                            r_estado  <= OCIOSO;
                        end
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign bus.chave_rodada = r_chave;
    assign bus.rodada       = r_rodada;
    assign bus.saida_valida = r_valida;
    assign bus.ocupado      = r_ocupado;
    assign bus.fim          = r_fim;
endmodule
